dual_port_boot_mem: RTL and testbench

- Parametrised successor to the CPU's flat 256x8 memory.
- Provides a read-only instruction-fetch port (A), a read/write data port (B), and a byte-stream boot-load port.
- After reset the block zero-fills the array, accepts a program image over the boot stream, then enters RUN and serves CPU accesses.
- Both read ports are registered, with 1-cycle latency.

---
 rtl/mem_pkg.sv | 13 +
 rtl/mem_array_2p.sv | 59 +++++
 rtl/dual_port_boot_mem.sv | 145 ++++++++++++++
 tb/tb_dual_port_boot_mem.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared memory-subsystem types and default widths used by the CPU core and boot memory.
package mem_pkg;

   localparam int unsigned MEM_DATA_W = 8;
   localparam int unsigned MEM_ADDR_W = 8;

   typedef enum logic [1:0] {
      CLEAR = 2'd0,
      BOOT  = 2'd1,
      RUN   = 2'd2
   } mem_state_e;

endpackage

// File: rtl/mem_array_2p.sv
// Storage with a read-only port A and a read/write port B; both reads are registered and read-first.
module mem_array_2p
   import mem_pkg::*;
#(
   parameter int unsigned DATA_W = MEM_DATA_W,
   parameter int unsigned ADDR_W = MEM_ADDR_W,
   parameter int unsigned DEPTH  = 2**ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              a_en,
   input  logic [ADDR_W-1:0] a_addr,
   output logic [DATA_W-1:0] a_rdata,
   output logic              a_rvalid,
   input  logic              b_en,
   input  logic              b_we,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_wdata,
   output logic [DATA_W-1:0] b_rdata,
   output logic              b_rvalid
);

   localparam int unsigned CNT_W = ADDR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic a_hit;
   logic b_hit;

   // Addresses beyond DEPTH read as zero and never write.
   assign a_hit = ({1'b0, a_addr} < DEPTH_CNT);
   assign b_hit = ({1'b0, b_addr} < DEPTH_CNT);

   always_ff @(posedge clk) begin
      if (b_en && b_we && b_hit) begin
         mem[b_addr] <= b_wdata;
      end
   end

   // Reads sample the array before this edge's write lands, giving read-first collisions.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_rdata  <= '0;
         a_rvalid <= 1'b0;
         b_rdata  <= '0;
         b_rvalid <= 1'b0;
      end else begin
         a_rvalid <= a_en;
         b_rvalid <= b_en && !b_we;
         if (a_en) begin
            a_rdata <= a_hit ? mem[a_addr] : '0;
         end
         if (b_en && !b_we) begin
            b_rdata <= b_hit ? mem[b_addr] : '0;
         end
      end
   end

endmodule

// File: rtl/dual_port_boot_mem.sv
// CPU memory with zero-fill after reset, optional byte-stream boot load, then fetch/data service.
module dual_port_boot_mem
   import mem_pkg::*;
#(
   parameter int unsigned DATA_W  = MEM_DATA_W,
   parameter int unsigned ADDR_W  = MEM_ADDR_W,
   parameter int unsigned DEPTH   = 2**ADDR_W,
   parameter bit          BOOT_EN = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              boot_valid,
   input  logic [DATA_W-1:0] boot_data,
   input  logic              boot_last,
   output logic              boot_ready,
   input  logic              a_en,
   input  logic [ADDR_W-1:0] a_addr,
   output logic [DATA_W-1:0] a_rdata,
   output logic              a_rvalid,
   input  logic              b_en,
   input  logic              b_we,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_wdata,
   output logic [DATA_W-1:0] b_rdata,
   output logic              b_rvalid,
   output logic              mem_ready,
   output logic              boot_err,
   output logic [ADDR_W:0]   boot_count
);

   localparam int unsigned CNT_W = ADDR_W + 1;
   localparam logic [ADDR_W-1:0] LAST_PTR  = ADDR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(DEPTH);

   mem_state_e state;
   mem_state_e state_nx;

   logic [ADDR_W-1:0] ptr;
   logic              boot_room;
   logic              boot_acc;
   logic              arr_a_en;
   logic              arr_b_en;
   logic              arr_b_we;
   logic [ADDR_W-1:0] arr_b_addr;
   logic [DATA_W-1:0] arr_b_wdata;

   assign boot_room = (boot_count < DEPTH_CNT);

   // State register; status flags are registered from the next state so they track it exactly.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= CLEAR;
         boot_ready <= 1'b0;
         mem_ready  <= 1'b0;
      end else begin
         state      <= state_nx;
         boot_ready <= (state_nx == BOOT);
         mem_ready  <= (state_nx == RUN);
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         CLEAR: if (ptr == LAST_PTR) state_nx = BOOT_EN ? BOOT : RUN;
         BOOT:  if (boot_valid && boot_last) state_nx = RUN;
         RUN:   state_nx = RUN;
         default: state_nx = CLEAR;
      endcase
   end

   // Port B's write path is shared by zero-fill, boot load and CPU data accesses.
   always_comb begin
      arr_a_en    = 1'b0;
      arr_b_en    = 1'b0;
      arr_b_we    = 1'b0;
      arr_b_addr  = '0;
      arr_b_wdata = '0;
      boot_acc    = 1'b0;
      case (state)
         CLEAR: begin
            arr_b_en   = 1'b1;
            arr_b_we   = 1'b1;
            arr_b_addr = ptr;
         end
         BOOT: begin
            boot_acc = boot_valid;
            if (boot_valid && boot_room) begin
               arr_b_en    = 1'b1;
               arr_b_we    = 1'b1;
               arr_b_addr  = boot_count[ADDR_W-1:0];
               arr_b_wdata = boot_data;
            end
         end
         RUN: begin
            arr_a_en    = a_en;
            arr_b_en    = b_en;
            arr_b_we    = b_we;
            arr_b_addr  = b_addr;
            arr_b_wdata = b_wdata;
         end
         default: ;
      endcase
   end

   // Clear pointer and boot bookkeeping; words beyond DEPTH are dropped and flagged.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr        <= '0;
         boot_count <= '0;
         boot_err   <= 1'b0;
      end else begin
         if (state == CLEAR) begin
            ptr <= ptr + ADDR_W'(1);
         end
         if (boot_acc) begin
            if (boot_room) begin
               boot_count <= boot_count + CNT_W'(1);
            end else begin
               boot_err <= 1'b1;
            end
         end
      end
   end

   mem_array_2p #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_array (
      .clk      (clk),
      .rst_n    (rst_n),
      .a_en     (arr_a_en),
      .a_addr   (a_addr),
      .a_rdata  (a_rdata),
      .a_rvalid (a_rvalid),
      .b_en     (arr_b_en),
      .b_we     (arr_b_we),
      .b_addr   (arr_b_addr),
      .b_wdata  (arr_b_wdata),
      .b_rdata  (b_rdata),
      .b_rvalid (b_rvalid)
   );

endmodule

// File: tb/tb_dual_port_boot_mem.sv
// Bench for dual_port_boot_mem: three configurations sharing stimulus, one active at a time.
module tb_dual_port_boot_mem;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst0, rst1, rst2;
   logic boot_valid, boot_last;
   logic [7:0] boot_data;
   logic a_en, b_en, b_we;
   logic [7:0] a_addr, b_addr, b_wdata;

   logic [7:0] a_rd0, b_rd0, a_rd1, b_rd1, a_rd2, b_rd2;
   logic a_rv0, b_rv0, br0, mr0, be0;
   logic a_rv1, b_rv1, br1, mr1, be1;
   logic a_rv2, b_rv2, br2, mr2, be2;
   logic [8:0] bc0, bc1;
   logic [4:0] bc2;

   int sel;
   logic [7:0] cur_a_rd, cur_b_rd;
   logic cur_a_rv, cur_b_rv, cur_br, cur_mr, cur_be;
   logic [8:0] cur_bc;

   dual_port_boot_mem #(.DATA_W(8), .ADDR_W(8), .DEPTH(256), .BOOT_EN(1'b0)) u0 (
      .clk(clk), .rst_n(rst0), .boot_valid(boot_valid), .boot_data(boot_data),
      .boot_last(boot_last), .boot_ready(br0), .a_en(a_en), .a_addr(a_addr),
      .a_rdata(a_rd0), .a_rvalid(a_rv0), .b_en(b_en), .b_we(b_we), .b_addr(b_addr),
      .b_wdata(b_wdata), .b_rdata(b_rd0), .b_rvalid(b_rv0), .mem_ready(mr0),
      .boot_err(be0), .boot_count(bc0));

   dual_port_boot_mem #(.DATA_W(8), .ADDR_W(8), .DEPTH(256), .BOOT_EN(1'b1)) u1 (
      .clk(clk), .rst_n(rst1), .boot_valid(boot_valid), .boot_data(boot_data),
      .boot_last(boot_last), .boot_ready(br1), .a_en(a_en), .a_addr(a_addr),
      .a_rdata(a_rd1), .a_rvalid(a_rv1), .b_en(b_en), .b_we(b_we), .b_addr(b_addr),
      .b_wdata(b_wdata), .b_rdata(b_rd1), .b_rvalid(b_rv1), .mem_ready(mr1),
      .boot_err(be1), .boot_count(bc1));

   dual_port_boot_mem #(.DATA_W(8), .ADDR_W(4), .DEPTH(16), .BOOT_EN(1'b1)) u2 (
      .clk(clk), .rst_n(rst2), .boot_valid(boot_valid), .boot_data(boot_data),
      .boot_last(boot_last), .boot_ready(br2), .a_en(a_en), .a_addr(a_addr[3:0]),
      .a_rdata(a_rd2), .a_rvalid(a_rv2), .b_en(b_en), .b_we(b_we), .b_addr(b_addr[3:0]),
      .b_wdata(b_wdata), .b_rdata(b_rd2), .b_rvalid(b_rv2), .mem_ready(mr2),
      .boot_err(be2), .boot_count(bc2));

   always_comb begin
      case (sel)
         0: begin
            cur_a_rd = a_rd0; cur_b_rd = b_rd0; cur_a_rv = a_rv0; cur_b_rv = b_rv0;
            cur_br = br0; cur_mr = mr0; cur_be = be0; cur_bc = bc0;
         end
         1: begin
            cur_a_rd = a_rd1; cur_b_rd = b_rd1; cur_a_rv = a_rv1; cur_b_rv = b_rv1;
            cur_br = br1; cur_mr = mr1; cur_be = be1; cur_bc = bc1;
         end
         default: begin
            cur_a_rd = a_rd2; cur_b_rd = b_rd2; cur_a_rv = a_rv2; cur_b_rv = b_rv2;
            cur_br = br2; cur_mr = mr2; cur_be = be2; cur_bc = 9'(bc2);
         end
      endcase
   end

   int tests;
   int failed;
   int n;
   int seen;
   logic [7:0] ref_mem [256];
   logic [7:0] m_a, m_b;

   typedef struct {
      logic       ae;
      logic [7:0] aa;
      logic       be;
      logic       bw;
      logic [7:0] ba;
      logic [7:0] bd;
      logic       xav;
      logic [7:0] xad;
      logic       xbv;
      logic [7:0] xbd;
   } vec_t;
   vec_t vecs [8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk4(input string tag, input logic xav, input logic [7:0] xad,
                       input logic xbv, input logic [7:0] xbd);
      chk({tag, "_a_rvalid"}, 32'(cur_a_rv), 32'(xav));
      chk({tag, "_a_rdata"},  32'(cur_a_rd), 32'(xad));
      chk({tag, "_b_rvalid"}, 32'(cur_b_rv), 32'(xbv));
      chk({tag, "_b_rdata"},  32'(cur_b_rd), 32'(xbd));
   endtask

   task automatic chk_reset(input string tag);
      chk4(tag, 1'b0, 8'h00, 1'b0, 8'h00);
      chk({tag, "_mem_ready"},  32'(cur_mr), 32'd0);
      chk({tag, "_boot_ready"}, 32'(cur_br), 32'd0);
      chk({tag, "_boot_err"},   32'(cur_be), 32'd0);
      chk({tag, "_boot_count"}, 32'(cur_bc), 32'd0);
   endtask

   // One bus cycle: inputs change at the falling edge, outputs sampled 1 ns after the rising edge.
   task automatic op(input logic ae, input logic [7:0] aa, input logic be, input logic bw,
                     input logic [7:0] ba, input logic [7:0] bd);
      @(negedge clk);
      boot_valid = 1'b0; boot_last = 1'b0;
      a_en = ae; a_addr = aa; b_en = be; b_we = bw; b_addr = ba; b_wdata = bd;
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic [7:0] d, input logic last);
      @(negedge clk);
      boot_valid = 1'b1; boot_data = d; boot_last = last;
      @(posedge clk);
      #1;
   endtask

   // Bounded wait for boot_ready (which=0) or mem_ready (which=1); counts edges and stray rvalids.
   task automatic wait_flag(input int which, input int limit, output int cnt, output int rv);
      cnt = 0;
      rv = 0;
      while (cnt < limit) begin
         @(posedge clk);
         #1;
         cnt++;
         if (cur_a_rv || cur_b_rv) rv++;
         if ((which == 0) ? cur_br : cur_mr) break;
      end
   endtask

   initial begin
      logic       ae, be, bw;
      logic [7:0] aa, ba, bd;
      logic       xbv;

      tests = 0; failed = 0; sel = 0;
      rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
      boot_valid = 1'b0; boot_last = 1'b0; boot_data = '0;
      a_en = 1'b0; a_addr = '0; b_en = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;

      vecs[0] = '{1'b0, 8'd0,   1'b1, 1'b1, 8'd200, 8'h05, 1'b0, 8'h00, 1'b0, 8'h00};
      vecs[1] = '{1'b0, 8'd0,   1'b1, 1'b0, 8'd200, 8'h00, 1'b0, 8'h00, 1'b1, 8'h05};
      vecs[2] = '{1'b1, 8'd201, 1'b1, 1'b1, 8'd201, 8'h0A, 1'b1, 8'h00, 1'b0, 8'h05};
      vecs[3] = '{1'b1, 8'd201, 1'b0, 1'b0, 8'd0,   8'h00, 1'b1, 8'h0A, 1'b0, 8'h05};
      vecs[4] = '{1'b1, 8'd1,   1'b1, 1'b0, 8'd0,   8'h00, 1'b1, 8'hC8, 1'b1, 8'h10};
      vecs[5] = '{1'b1, 8'd3,   1'b0, 1'b0, 8'd0,   8'h00, 1'b1, 8'hC9, 1'b0, 8'h10};
      vecs[6] = '{1'b0, 8'd0,   1'b1, 1'b0, 8'd201, 8'h00, 1'b0, 8'hC9, 1'b1, 8'h0A};
      vecs[7] = '{1'b1, 8'd2,   1'b1, 1'b0, 8'd3,   8'h00, 1'b1, 8'h14, 1'b1, 8'hC9};

      // Zero-fill only, no boot stage.
      repeat (3) @(negedge clk);
      chk_reset("u0_reset");
      @(negedge clk);
      rst0 = 1'b1;
      wait_flag(1, 1000, n, seen);
      chk("u0_clear_cycles", 32'(n), 32'd256);
      chk("u0_boot_ready_run", 32'(cur_br), 32'd0);
      op(1'b0, 8'd0, 1'b1, 1'b0, 8'd100, 8'd0);
      chk4("u0_rd100", 1'b0, 8'h00, 1'b1, 8'h00);
      @(negedge clk);
      rst0 = 1'b0;

      // Boot load with gated CPU requests during CLEAR and BOOT.
      sel = 1;
      @(negedge clk);
      a_en = 1'b1; a_addr = 8'd50; b_en = 1'b1; b_we = 1'b1; b_addr = 8'd50; b_wdata = 8'hAA;
      rst1 = 1'b1;
      wait_flag(0, 1000, n, seen);
      chk("u1_clear_cycles", 32'(n), 32'd256);
      chk("u1_gate_clear_rvalid", 32'(seen), 32'd0);
      op(1'b1, 8'd51, 1'b1, 1'b1, 8'd51, 8'hBB);
      chk4("u1_gate_boot_wr", 1'b0, 8'h00, 1'b0, 8'h00);
      op(1'b1, 8'd52, 1'b1, 1'b0, 8'd52, 8'h00);
      chk4("u1_gate_boot_rd", 1'b0, 8'h00, 1'b0, 8'h00);
      chk("u1_count_pre", 32'(cur_bc), 32'd0);
      chk("u1_ready_pre", 32'(cur_mr), 32'd0);
      beat(8'h10, 1'b0);
      beat(8'hC8, 1'b0);
      beat(8'h14, 1'b0);
      beat(8'hC9, 1'b1);
      chk("u1_boot_count", 32'(cur_bc), 32'd4);
      chk("u1_mem_ready", 32'(cur_mr), 32'd1);
      chk("u1_boot_ready_off", 32'(cur_br), 32'd0);
      chk("u1_boot_err", 32'(cur_be), 32'd0);

      for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
      ref_mem[0] = 8'h10; ref_mem[1] = 8'hC8; ref_mem[2] = 8'h14; ref_mem[3] = 8'hC9;

      for (int i = 0; i < 8; i++) begin
         op(vecs[i].ae, vecs[i].aa, vecs[i].be, vecs[i].bw, vecs[i].ba, vecs[i].bd);
         chk4($sformatf("vec%0d", i), vecs[i].xav, vecs[i].xad, vecs[i].xbv, vecs[i].xbd);
         if (vecs[i].be && vecs[i].bw) ref_mem[vecs[i].ba] = vecs[i].bd;
      end

      op(1'b1, 8'd50, 1'b1, 1'b0, 8'd51, 8'h00);
      chk4("u1_gated_locs", 1'b1, 8'h00, 1'b1, 8'h00);
      m_a = 8'h00;
      m_b = 8'h00;

      // Random RUN traffic against a read-first array model.
      for (int i = 0; i < 400; i++) begin
         ae = 1'($urandom_range(0, 1));
         be = 1'($urandom_range(0, 1));
         bw = 1'($urandom_range(0, 1));
         aa = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
         ba = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
         bd = 8'($urandom);
         xbv = be && !bw;
         if (ae) m_a = ref_mem[aa];
         if (xbv) m_b = ref_mem[ba];
         op(ae, aa, be, bw, ba, bd);
         chk4($sformatf("rand%0d", i), ae, m_a, xbv, m_b);
         if (be && bw) ref_mem[ba] = bd;
      end
      @(negedge clk);
      rst1 = 1'b0;

      // Overflow on a 16-word instance.
      sel = 2;
      op(1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 8'd0);
      @(negedge clk);
      rst2 = 1'b1;
      wait_flag(0, 200, n, seen);
      chk("u2_clear_cycles", 32'(n), 32'd16);
      for (int i = 1; i <= 17; i++) begin
         beat(8'(i), (i == 17));
         if (i == 16) begin
            chk("u2_err_at_16", 32'(cur_be), 32'd0);
            chk("u2_count_at_16", 32'(cur_bc), 32'd16);
         end
      end
      chk("u2_boot_err", 32'(cur_be), 32'd1);
      chk("u2_boot_count", 32'(cur_bc), 32'd16);
      chk("u2_mem_ready", 32'(cur_mr), 32'd1);
      op(1'b1, 8'd0, 1'b1, 1'b0, 8'd15, 8'd0);
      chk4("u2_ends", 1'b1, 8'h01, 1'b1, 8'h10);
      op(1'b1, 8'd1, 1'b0, 1'b0, 8'd0, 8'd0);
      chk4("u2_addr1", 1'b1, 8'h02, 1'b0, 8'h10);
      @(negedge clk);
      rst2 = 1'b0;

      // Reset pulse mid-boot erases the partial image.
      sel = 1;
      @(negedge clk);
      rst1 = 1'b1;
      wait_flag(0, 1000, n, seen);
      chk("u1b_clear_cycles", 32'(n), 32'd256);
      beat(8'hAA, 1'b0);
      beat(8'hBB, 1'b0);
      beat(8'hCC, 1'b0);
      chk("u1b_partial_count", 32'(cur_bc), 32'd3);
      @(negedge clk);
      boot_valid = 1'b0;
      #2;
      rst1 = 1'b0;
      #1;
      chk_reset("u1b_midreset");
      @(negedge clk);
      rst1 = 1'b1;
      wait_flag(0, 1000, n, seen);
      chk("u1b_reclear_cycles", 32'(n), 32'd256);
      beat(8'h00, 1'b1);
      chk("u1b_mem_ready", 32'(cur_mr), 32'd1);
      chk("u1b_boot_count", 32'(cur_bc), 32'd1);
      op(1'b1, 8'd0, 1'b1, 1'b0, 8'd1, 8'd0);
      chk4("u1b_erased01", 1'b1, 8'h00, 1'b1, 8'h00);
      op(1'b1, 8'd2, 1'b0, 1'b0, 8'd0, 8'd0);
      chk4("u1b_erased2", 1'b1, 8'h00, 1'b0, 8'h00);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
